// File: rtl/decode_stage.sv
// decode_stage: instruction decode with register file, load scoreboard,
// write-back bypass and a valid/ready ID/EX pipeline register.
module decode_stage #(
    parameter int BUS        = 32,
    parameter int NREG       = 16,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    instruction,
    input  logic [BUS-1:0] PCi,
    input  logic           WE,
    input  logic [3:0]     RDwb,
    input  logic [BUS-1:0] WBd,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BUS-1:0] OPA,
    output logic [BUS-1:0] OPB,
    output logic [BUS-1:0] STR_DATA,
    output logic [BUS-1:0] RKo,
    output logic [BUS-1:0] PCo,
    output logic [3:0]     RDo,
    output logic [1:0]     FUNTYPE,
    output logic [1:0]     FUNCODE,
    output logic           selWB,
    output logic           selMEMRD,
    output logic           selMEMWR,
    output logic           selCACHEWR,
    output logic           selCACHESH,
    output logic           selBRANCH,
    output logic           illegal
);
    localparam logic [4:0] NREG_W = 5'(NREG);

    // Instruction fields
    logic [1:0]  f_type, f_code;
    logic [3:0]  f_rd, f_rs, f_rt;
    logic [14:0] f_imm;
    logic        f_i;

    assign f_type = instruction[31:30];
    assign f_code = instruction[29:28];
    assign f_rd   = instruction[27:24];
    assign f_rs   = instruction[23:20];
    assign f_rt   = instruction[19:16];
    assign f_imm  = instruction[15:1];
    assign f_i    = instruction[0];

    // Register file, scoreboard and ID/EX state
    logic [BUS-1:0]  regs_reg [NREG];
    logic [NREG-1:0] pend_reg, pend_next;
    logic [NREG-1:0] wr_hit;
    logic            valid_reg;
    logic [BUS-1:0]  opa_reg, opb_reg, str_reg, rk_reg, pc_reg;
    logic [3:0]      rdo_reg;
    logic [1:0]      ft_reg, fc_reg;
    logic [6:0]      sel_reg;

    logic        ld_leave;
    logic        hazard;
    logic        accept;

    // Per-register write-back hit and scoreboard next state (set beats clear)
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [3:0] IDX = 4'(gi);
            assign wr_hit[gi]    = WE && (RDwb == IDX);
            assign pend_next[gi] = (ld_leave && (rdo_reg == IDX)) ? 1'b1 :
                                   (wr_hit[gi] ? 1'b0 : pend_reg[gi]);
        end
    endgenerate

    // Register read with same-cycle write-back bypass; out-of-range reads 0
    function automatic logic [BUS-1:0] rd_port(input logic [3:0] idx);
        logic [BUS-1:0] v;
        v = '0;
        if ({1'b0, idx} < NREG_W) begin
            if (WE && (RDwb == idx))
                v = WBd;
            else
                v = regs_reg[idx];
        end
        return v;
    endfunction

    // A source blocks only if its load is outstanding and not returning now
    function automatic logic src_blocked(input logic [3:0] idx);
        logic b;
        b = 1'b0;
        if ({1'b0, idx} < NREG_W)
            b = pend_reg[idx] && !(WE && (RDwb == idx));
        return b;
    endfunction

    logic [BUS-1:0] imm_ext;
    generate
        if (IMM_SIGNED) begin : g_sext
            assign imm_ext = {{(BUS-15){f_imm[14]}}, f_imm};
        end else begin : g_zext
            assign imm_ext = {{(BUS-15){1'b0}}, f_imm};
        end
    endgenerate

    // Control select decode: {WB, MEMRD, MEMWR, CACHEWR, CACHESH, BRANCH, illegal}
    logic [6:0] dec_sel;
    always_comb begin
        dec_sel = 7'b0000000;
        case ({f_type, f_code})
            4'b0000, 4'b0001, 4'b0010: dec_sel = 7'b1000000;
            4'b0011:                   dec_sel = 7'b0000000;
            4'b0100:                   dec_sel = 7'b1100000;
            4'b0101:                   dec_sel = 7'b0010000;
            4'b1000, 4'b1001:          dec_sel = 7'b1000010;
            4'b1100, 4'b1110:          dec_sel = 7'b1000000;
            4'b1101:                   dec_sel = 7'b0001000;
            4'b1111:                   dec_sel = 7'b0000100;
            default:                   dec_sel = 7'b0000001;
        endcase
    end

    // Load-use hazard and handshake
    always_comb begin
        hazard = in_valid && (src_blocked(f_rs) ||
                              (!f_i && src_blocked(f_rt)) ||
                              (dec_sel[4] && src_blocked(f_rd)));
        in_ready = !flush && !hazard && (!valid_reg || out_ready);
        accept   = in_valid && in_ready;
        ld_leave = valid_reg && out_ready && sel_reg[5] && !flush;
    end

    // Register file write, independent of stall and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (wr_hit[i]) regs_reg[i] <= WBd;
        end
    end

    // Load scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_reg <= '0;
        else        pend_reg <= pend_next;
    end

    // ID/EX pipeline register: load on accept, bubble on consume or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            opa_reg   <= '0;
            opb_reg   <= '0;
            str_reg   <= '0;
            rk_reg    <= '0;
            pc_reg    <= '0;
            rdo_reg   <= '0;
            ft_reg    <= '0;
            fc_reg    <= '0;
            sel_reg   <= '0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            opa_reg   <= rd_port(f_rs);
            opb_reg   <= f_i ? imm_ext : rd_port(f_rt);
            str_reg   <= rd_port(f_rd);
            rk_reg    <= rd_port(f_rt);
            pc_reg    <= PCi;
            rdo_reg   <= f_rd;
            ft_reg    <= f_type;
            fc_reg    <= f_code;
            sel_reg   <= dec_sel;
        end else if (flush || out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid  = valid_reg;
    assign OPA        = opa_reg;
    assign OPB        = opb_reg;
    assign STR_DATA   = str_reg;
    assign RKo        = rk_reg;
    assign PCo        = pc_reg;
    assign RDo        = rdo_reg;
    assign FUNTYPE    = ft_reg;
    assign FUNCODE    = fc_reg;
    assign selWB      = sel_reg[6];
    assign selMEMRD   = sel_reg[5];
    assign selMEMWR   = sel_reg[4];
    assign selCACHEWR = sel_reg[3];
    assign selCACHESH = sel_reg[2];
    assign selBRANCH  = sel_reg[1];
    assign illegal    = sel_reg[0];

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: opcode table sweep, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] PCi;
    logic        WE;
    logic [3:0]  RDwb;
    logic [31:0] WBd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] OPA, OPB, STR_DATA, RKo, PCo;
    logic [3:0]  RDo;
    logic [1:0]  FUNTYPE, FUNCODE;
    logic        selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH, illegal;

    decode_stage #(.BUS(32), .NREG(16), .IMM_SIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .PCi(PCi), .WE(WE), .RDwb(RDwb), .WBd(WBd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .OPA(OPA), .OPB(OPB), .STR_DATA(STR_DATA), .RKo(RKo), .PCo(PCo),
        .RDo(RDo), .FUNTYPE(FUNTYPE), .FUNCODE(FUNCODE),
        .selWB(selWB), .selMEMRD(selMEMRD), .selMEMWR(selMEMWR),
        .selCACHEWR(selCACHEWR), .selCACHESH(selCACHESH),
        .selBRANCH(selBRANCH), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [6:0] dut_sel;
    assign dut_sel = {selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH, illegal};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt,
                                       input logic [14:0] imm, input logic i);
        return {op, rd, rs, rt, imm, i};
    endfunction

    // Opcode sweep table: select vector {WB,MEMRD,MEMWR,CACHEWR,CACHESH,BRANCH,illegal}
    typedef struct packed {
        logic [3:0]  op;
        logic [14:0] imm;
        logic [6:0]  sel;
        logic [31:0] opb;
    } vec_t;
    vec_t vecs [14];

    // Reference model state
    typedef struct {
        logic [31:0] opa, opb, strd, rk, pc;
        logic [3:0]  rd;
        logic [3:0]  op;
        logic [6:0]  sel;
    } pkt_t;
    logic [31:0] m_regs [16];
    logic        m_pend [16];
    logic        m_valid;
    pkt_t        m_pkt;
    logic [6:0]  sel_tab [16];

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        if (WE && RDwb == idx) return WBd;
        return m_regs[idx];
    endfunction

    function automatic logic m_stall_on(input logic [3:0] idx);
        return m_pend[idx] && !(WE && RDwb == idx);
    endfunction

    initial begin
        vecs[0]  = '{4'b0000, 15'h0000, 7'b1000000, 32'h0000_0000};
        vecs[1]  = '{4'b0001, 15'h0001, 7'b1000000, 32'h0000_0001};
        vecs[2]  = '{4'b0010, 15'h4000, 7'b1000000, 32'hFFFF_C000};
        vecs[3]  = '{4'b0011, 15'h3FFF, 7'b0000000, 32'h0000_3FFF};
        vecs[4]  = '{4'b0100, 15'h7FFF, 7'b1100000, 32'hFFFF_FFFF};
        vecs[5]  = '{4'b0101, 15'h0123, 7'b0010000, 32'h0000_0123};
        vecs[6]  = '{4'b0110, 15'h0000, 7'b0000001, 32'h0000_0000};
        vecs[7]  = '{4'b1000, 15'h7FFE, 7'b1000010, 32'hFFFF_FFFE};
        vecs[8]  = '{4'b1001, 15'h0002, 7'b1000010, 32'h0000_0002};
        vecs[9]  = '{4'b1011, 15'h0010, 7'b0000001, 32'h0000_0010};
        vecs[10] = '{4'b1100, 15'h5555, 7'b1000000, 32'hFFFF_D555};
        vecs[11] = '{4'b1101, 15'h2AAA, 7'b0001000, 32'h0000_2AAA};
        vecs[12] = '{4'b1110, 15'h0100, 7'b1000000, 32'h0000_0100};
        vecs[13] = '{4'b1111, 15'h0080, 7'b0000100, 32'h0000_0080};
        for (int k = 0; k < 16; k++) sel_tab[k] = 7'b0000001;
        for (int k = 0; k < 14; k++) sel_tab[vecs[k].op] = vecs[k].sel;

        rst_n = 1'b0; in_valid = 1'b0; instruction = '0; PCi = '0;
        WE = 1'b0; RDwb = '0; WBd = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_opa", OPA, 32'd0);
        chk("reset_sel", {25'b0, dut_sel}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Write r8 = 3, then ADD r1, r8, r2
        tick();
        WE = 1'b1; RDwb = 4'd8; WBd = 32'd3;
        tick();
        WE = 1'b0;
        in_valid = 1'b1; instruction = mk(4'b0000, 4'd1, 4'd8, 4'd2, 15'h0, 1'b0); PCi = 32'h100;
        tick();
        in_valid = 1'b0;
        $display("txn add: opa=%h opb=%h", OPA, OPB);
        chk("add_out_valid", {31'b0, out_valid}, 32'd1);
        chk("add_opa", OPA, 32'd3);
        chk("add_opb", OPB, 32'd0);
        chk("add_funtype", {30'b0, FUNTYPE}, 32'd0);
        chk("add_sel", {25'b0, dut_sel}, 32'b1000000);
        chk("add_pco", PCo, 32'h100);
        tick();

        // Opcode sweep, back to back
        for (int k = 0; k < 14; k++) begin
            in_valid = 1'b1;
            instruction = mk(vecs[k].op, (vecs[k].op == 4'b0100) ? 4'd15 : 4'd1,
                             4'd0, 4'd0, vecs[k].imm, 1'b1);
            PCi = 32'h200 + 32'(k * 4);
            #1 chk("sweep_in_ready", {31'b0, in_ready}, 32'd1);
            tick();
            $display("txn sweep op=%b sel=%b opb=%h", vecs[k].op, dut_sel, OPB);
            chk("sweep_valid", {31'b0, out_valid}, 32'd1);
            chk("sweep_sel", {25'b0, dut_sel}, {25'b0, vecs[k].sel});
            chk("sweep_opb", OPB, vecs[k].opb);
            chk("sweep_op", {28'b0, FUNTYPE, FUNCODE}, {28'b0, vecs[k].op});
        end
        in_valid = 1'b0;
        tick();

        // Same-cycle bypass into MOV
        WE = 1'b1; RDwb = 4'd2; WBd = 32'h55;
        in_valid = 1'b1; instruction = mk(4'b0010, 4'd3, 4'd2, 4'd0, 15'h0, 1'b1);
        tick();
        WE = 1'b0; in_valid = 1'b0;
        $display("txn bypass: opa=%h", OPA);
        chk("bypass_opa", OPA, 32'h55);
        tick();

        // Load-use: LDR r4 leaves, dependent ADD stalls until write-back
        in_valid = 1'b1; instruction = mk(4'b0100, 4'd4, 4'd0, 4'd0, 15'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; instruction = mk(4'b0000, 4'd5, 4'd4, 4'd0, 15'h0, 1'b0);
        #1 chk("loaduse_stall_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("loaduse_bubble", {31'b0, out_valid}, 32'd0);
        WE = 1'b1; RDwb = 4'd4; WBd = 32'd9;
        #1 chk("loaduse_wb_ready", {31'b0, in_ready}, 32'd1);
        tick();
        WE = 1'b0; in_valid = 1'b0;
        $display("txn loaduse: opa=%h", OPA);
        chk("loaduse_valid", {31'b0, out_valid}, 32'd1);
        chk("loaduse_opa", OPA, 32'd9);
        tick();

        // Backpressure: hold A for 3 cycles while B waits
        in_valid = 1'b1; instruction = mk(4'b0000, 4'd1, 4'd8, 4'd0, 15'h0, 1'b1);
        tick();
        out_ready = 1'b0;
        instruction = mk(4'b0001, 4'd2, 4'd2, 4'd0, 15'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_opa_held", OPA, 32'd3);
            chk("bp_funcode_held", {30'b0, FUNCODE}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        $display("txn backpressure: opa=%h funcode=%0d", OPA, FUNCODE);
        chk("bp_b_opa", OPA, 32'h55);
        chk("bp_b_funcode", {30'b0, FUNCODE}, 32'd1);
        tick();
        chk("bp_no_dup", {31'b0, out_valid}, 32'd0);

        // Flush with an LDR held: dropped and no scoreboard set
        in_valid = 1'b1; instruction = mk(4'b0100, 4'd6, 4'd0, 4'd0, 15'h0, 1'b1);
        tick();
        flush = 1'b1; instruction = mk(4'b0000, 4'd10, 4'd3, 4'd0, 15'h0, 1'b1);
        #1 chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        instruction = mk(4'b0000, 4'd11, 4'd6, 4'd0, 15'h0, 1'b1);
        #1 chk("flush_no_pend", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("flush_next_rdo", {28'b0, RDo}, 32'd11);
        tick();

        // Async reset mid-stall
        in_valid = 1'b1; instruction = mk(4'b0100, 4'd7, 4'd0, 4'd0, 15'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; instruction = mk(4'b0010, 4'd12, 4'd8, 4'd0, 15'h0, 1'b1);
        tick();
        out_ready = 1'b0;
        instruction = mk(4'b0000, 4'd13, 4'd7, 4'd8, 15'h0, 1'b0);
        #1 chk("rst_stall_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("rst_pre_opa", OPA, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_async_opa", OPA, 32'd0);
        chk("rst_async_rdo", {28'b0, RDo}, 32'd0);
        chk("rst_async_sel", {25'b0, dut_sel}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("rst_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("rst_regfile_opb", OPB, 32'd0);
        chk("rst_after_valid", {31'b0, out_valid}, 32'd1);
        tick();

        // Randomized run against the reference model (state follows reset)
        for (int k = 0; k < 16; k++) begin m_regs[k] = '0; m_pend[k] = 1'b0; end
        m_valid = 1'b0;
        m_pkt = '{default: '0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       exp_ready, acc, leave_ld, stall;
            logic [3:0] op, rd, rs, rt;
            logic       ibit;
            pkt_t       npkt;
            in_valid  = ($urandom_range(0, 9) < 7);
            op = 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 3)); rs = 4'($urandom_range(0, 3));
            rt = 4'($urandom_range(0, 3)); ibit = 1'($urandom_range(0, 1));
            instruction = mk(op, rd, rs, rt, 15'($urandom), ibit);
            PCi       = $urandom;
            WE        = ($urandom_range(0, 9) < 3);
            RDwb      = 4'($urandom_range(0, 4));
            WBd       = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            stall = m_stall_on(rs) || (!ibit && m_stall_on(rt)) ||
                    ((op == 4'b0101) && m_stall_on(rd));
            exp_ready = !flush && !(in_valid && stall) && (!m_valid || out_ready);
            chk("rand_in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
            acc = in_valid && exp_ready;
            leave_ld = m_valid && out_ready && (m_pkt.sel == 7'b1100000) && !flush;
            npkt.opa  = m_read(rs);
            npkt.opb  = ibit ? 32'($signed(instruction[15:1])) : m_read(rt);
            npkt.strd = m_read(rd);
            npkt.rk   = m_read(rt);
            npkt.pc   = PCi;
            npkt.rd   = rd;
            npkt.op   = op;
            npkt.sel  = sel_tab[op];
            if (WE) begin m_pend[RDwb] = 1'b0; m_regs[RDwb] = WBd; end
            if (leave_ld) m_pend[m_pkt.rd] = 1'b1;
            if (acc) begin
                m_pkt = npkt;
                m_valid = 1'b1;
            end else if (out_ready || flush) begin
                m_valid = 1'b0;
            end
            tick();
            chk("rand_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (acc)
                $display("txn rand %0d: op=%b rd=%0d opa=%h opb=%h", cyc, op, rd, OPA, OPB);
            if (m_valid) begin
                chk("rand_opa", OPA, m_pkt.opa);
                chk("rand_opb", OPB, m_pkt.opb);
                chk("rand_str", STR_DATA, m_pkt.strd);
                chk("rand_rk", RKo, m_pkt.rk);
                chk("rand_pc", PCo, m_pkt.pc);
                chk("rand_ctrl", {17'b0, RDo, FUNTYPE, FUNCODE, dut_sel},
                    {17'b0, m_pkt.rd, m_pkt.op, m_pkt.sel});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction-decode stage: splits the 32-bit instruction word, reads a parametrised register file, generates control selects and registers everything into an ID/EX pipeline register with valid/ready handshakes on both sides. A per-register load scoreboard blocks load-use hazards, and a same-cycle write-back bypass covers read-after-write. It sits between fetch and execute and replaces the single-cycle combinational decoder.

## Interface
- BUS, 32: datapath width of registers, operands, PC.
- NREG, 16: number of architectural registers (2..16); indices >= NREG read 0, writes ignored.
- IMM_SIGNED, 1: 1 = sign-extend imm15, 0 = zero-extend.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents instruction/PCi.
- in_ready  out  1  stage accepts this cycle.
- instruction  in  32  [31:30] FUNTYPE, [29:28] FUNCODE, [27:24] RD, [23:20] RS, [19:16] RT, [15:1] imm15, [0] I flag.
- PCi  in  BUS  PC of instruction.
- WE  in  1  write-back enable.
- RDwb  in  4  write-back register index.
- WBd  in  BUS  write-back data.
- flush  in  1  kill the held and incoming instruction (taken branch).
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute consumes ID/EX contents.
- OPA, OPB, STR_DATA, RKo, PCo  out  BUS  registered operands/PC.
- RDo  out  4; FUNTYPE, FUNCODE  out  2 each.
- selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH, illegal  out  1 each.

## Operation
- Operands: OPA = R[RS]; OPB = I ? ext(imm15) : R[RT]; STR_DATA = R[RD]; RKo = R[RT]; PCo = PCi.
- Read bypass: if WE and RDwb == source index (< NREG), source reads WBd instead of the array.
- Control decode (FUNTYPE,FUNCODE):
  - ADD 00/00, SUB 00/01, MOV 00/10: selWB.
  - CMP 00/11: none.
  - LDR 01/00: selWB + selMEMRD.
  - STR 01/01: selMEMWR.
  - B 10/00, BEQ 10/01: selWB + selBRANCH.
  - KRN 11/00, LDK 11/10: selWB.
  - LKN 11/01: selCACHEWR.
  - SHK 11/11: selCACHESH.
  - 01/1x and 10/1x: all selects 0, illegal = 1; the instruction still flows through.
- Scoreboard: pend[NREG] bits.
  - Set pend[RDo] when an LDR leaves the stage (out_valid & out_ready & selMEMRD).
  - Clear pend[RDwb] on WE.
  - Set and clear of the same index in the same cycle: set wins.
- Hazard: an incoming instruction stalls while pend[s] = 1 for any source s it uses (RS; RT if I = 0; RD if STR) and no same-cycle WE with RDwb == s.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Accept (in_valid & in_ready): ID/EX loads all decoded fields; out_valid = 1.
- Consume without accept: out_valid = 0 (bubble); other fields hold.
- flush: out_valid = 0 next edge and the incoming instruction is dropped. The scoreboard is not set by a flushed LDR, even if out_ready is high that cycle.
- Register file write: R[RDwb] <= WBd on the clk edge when WE and RDwb < NREG. The write is independent of stall and flush.

## Timing
- Latency: 1 cycle from accept to out_valid/outputs.
- Throughput: 1 instruction per cycle with no hazard.
- A load-use stalls until the cycle WE matches that register. The consumer is accepted in that same cycle via the bypass.
- ID/EX outputs are stable while out_valid & !out_ready.
- Reset (async assert, any cycle including mid-stall):
  - All outputs and the register file go to 0; scoreboard is cleared.
  - out_valid = 0; in_ready = 1 once rst_n is high, given no flush.
- Flush and out_ready in the same cycle: the instruction counts as consumed by execute for handshake purposes, but the scoreboard is not updated.

## Test plan
- Reset, then write WBd = 3 to r8 (WE = 1), then ADD r1, r8, r2 with I = 0 -> next cycle OPA = 3, FUNTYPE = 00, selWB = 1, all other selects 0.
- Sweep all 12 legal opcodes plus 01/10 and 10/11 with out_ready = 1 -> select vectors match the decode list; the two undefined codes give illegal = 1 with all selects 0.
- Same-cycle bypass: WE = 1, RDwb = 2, WBd = 0x55 while decoding MOV with RS = 2 -> OPA = 0x55 one cycle later.
- Load-use: LDR r4 issues, then ADD reading r4 -> in_ready = 0, out_valid = 0 bubble. Assert WE, RDwb = 4, WBd = 9 -> accepted that cycle, OPA = 9 next cycle.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> outputs held, in_ready = 0. Release -> the next instruction loads 1 cycle later with no loss or duplication.
- flush with a valid LDR held and in_valid = 1 -> out_valid = 0 next cycle, pend unchanged. Async rst_n low mid-stall -> all outputs 0 immediately.
